bsg_fsb_node_iso_ls: RTL and testbench



---
 rtl/bsg_fsb_pkg.sv | 26 ++
 rtl/bsg_counter_clear_up.sv | 26 ++
 rtl/bsg_fsb_node_iso_ls.sv | 135 +++++++++++++
 tb/tb_bsg_fsb_node_iso_ls.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_fsb_pkg.sv
// Shared definitions for the fsb node isolation logic: the isolation FSM state
// encoding and helpers that decode which data directions a state lets through.
package bsg_fsb_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'b00,
    ST_DRAIN    = 2'b01,
    ST_ISOLATED = 2'b10,
    ST_WAKE     = 2'b11
  } fsb_iso_state_e;

  // fsb-to-node traffic is only admitted while fully active
  function automatic logic fwd_open(input fsb_iso_state_e s);
    return (s == ST_ACTIVE);
  endfunction

  // node-to-fsb traffic keeps flowing while the node drains its output
  function automatic logic rev_open(input fsb_iso_state_e s);
    return (s == ST_ACTIVE) || (s == ST_DRAIN);
  endfunction

  function automatic logic node_held(input fsb_iso_state_e s);
    return (s == ST_ISOLATED) || (s == ST_WAKE);
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Saturating up-counter with synchronous clear; holds at max_val_p instead of
// wrapping.
module bsg_counter_clear_up #(
  parameter int max_val_p = 4,
  parameter int width_lp  = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  logic [width_lp-1:0] count_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      count_reg <= '0;
    end else if (up_i && (count_reg != width_lp'(max_val_p))) begin
      count_reg <= count_reg + width_lp'(1);
    end
  end

  assign count_o = count_reg;

endmodule

// File: rtl/bsg_fsb_node_iso_ls.sv
// Isolates a node from the fsb: drains node output, gates all channels, holds
// the node in reset while isolated and for a fixed wake period afterwards.
module bsg_fsb_node_iso_ls
  import bsg_fsb_pkg::*;
#(
  parameter int width_p         = 80,
  parameter int num_ch_p        = 1,
  parameter int drain_quiet_p   = 4,
  parameter int drain_timeout_p = 64,
  parameter int wake_cycles_p   = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         iso_req_i,

  input  logic [num_ch_p-1:0]          fsb_v_o_i,
  input  logic [num_ch_p*width_p-1:0]  fsb_data_o_i,
  input  logic [num_ch_p-1:0]          node_ready_o_i,
  output logic [num_ch_p-1:0]          node_v_i_o,
  output logic [num_ch_p*width_p-1:0]  node_data_i_o,
  output logic [num_ch_p-1:0]          fsb_ready_i_o,

  input  logic [num_ch_p-1:0]          node_v_o_i,
  input  logic [num_ch_p*width_p-1:0]  node_data_o_i,
  input  logic [num_ch_p-1:0]          fsb_yumi_o_i,
  output logic [num_ch_p-1:0]          fsb_v_i_o,
  output logic [num_ch_p*width_p-1:0]  fsb_data_i_o,
  output logic [num_ch_p-1:0]          node_yumi_i_o,

  output logic                         node_reset_o,
  output logic                         iso_o,
  output logic                         drain_timeout_o
);

  localparam int quiet_w_lp   = $clog2(drain_quiet_p + 1);
  localparam int timeout_w_lp = $clog2(drain_timeout_p + 1);
  localparam int wake_w_lp    = $clog2(wake_cycles_p + 1);

  fsb_iso_state_e state_reg, state_next;
  logic fwd_open_reg, rev_open_reg, iso_reg, node_held_reg, drain_timeout_reg;

  logic in_drain, in_wake, node_busy;
  logic quiet_hit, timeout_hit, wake_done;
  logic [quiet_w_lp-1:0]   quiet_cnt;
  logic [timeout_w_lp-1:0] timeout_cnt;
  logic [wake_w_lp-1:0]    wake_cnt;

  assign in_drain  = (state_reg == ST_DRAIN);
  assign in_wake   = (state_reg == ST_WAKE);
  assign node_busy = |node_v_o_i;

  // Counters are held clear outside their own state, so each starts at 0 on entry.
  bsg_counter_clear_up #(.max_val_p(drain_quiet_p)) quiet_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (~in_drain | node_busy),
    .up_i    (in_drain & ~node_busy),
    .count_o (quiet_cnt)
  );

  bsg_counter_clear_up #(.max_val_p(drain_timeout_p)) timeout_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (~in_drain),
    .up_i    (in_drain),
    .count_o (timeout_cnt)
  );

  bsg_counter_clear_up #(.max_val_p(wake_cycles_p)) wake_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (~in_wake),
    .up_i    (in_wake),
    .count_o (wake_cnt)
  );

  // A limit is reached on the cycle whose increment would land on it.
  assign quiet_hit   = in_drain & ~node_busy & (quiet_cnt == quiet_w_lp'(drain_quiet_p - 1));
  assign timeout_hit = in_drain & (timeout_cnt == timeout_w_lp'(drain_timeout_p - 1));
  assign wake_done   = in_wake & (wake_cnt == wake_w_lp'(wake_cycles_p - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_ACTIVE:   if (iso_req_i) state_next = ST_DRAIN;
      ST_DRAIN:    if (quiet_hit || timeout_hit) state_next = ST_ISOLATED;
      ST_ISOLATED: if (!iso_req_i) state_next = ST_WAKE;
      ST_WAKE: begin
        if (iso_req_i)      state_next = ST_ISOLATED;
        else if (wake_done) state_next = ST_ACTIVE;
      end
      default:     state_next = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg         <= ST_ACTIVE;
      fwd_open_reg      <= 1'b1;
      rev_open_reg      <= 1'b1;
      iso_reg           <= 1'b0;
      node_held_reg     <= 1'b0;
      drain_timeout_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fwd_open_reg  <= fwd_open(state_next);
      rev_open_reg  <= rev_open(state_next);
      iso_reg       <= (state_next == ST_ISOLATED);
      node_held_reg <= node_held(state_next);
      // a simultaneous quiet hit means the node did drain, so no timeout flag
      if (timeout_hit && !quiet_hit) begin
        drain_timeout_reg <= 1'b1;
      end else if (in_wake && (state_next == ST_ACTIVE)) begin
        drain_timeout_reg <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < num_ch_p; gi++) begin : g_ch
    assign node_v_i_o[gi]    = fsb_v_o_i[gi] & fwd_open_reg;
    assign fsb_ready_i_o[gi] = node_ready_o_i[gi] & fwd_open_reg;
    assign node_data_i_o[gi*width_p +: width_p] =
      fsb_data_o_i[gi*width_p +: width_p] & {width_p{fwd_open_reg}};

    assign fsb_v_i_o[gi]     = node_v_o_i[gi] & rev_open_reg;
    assign node_yumi_i_o[gi] = fsb_yumi_o_i[gi] & rev_open_reg;
    assign fsb_data_i_o[gi*width_p +: width_p] =
      node_data_o_i[gi*width_p +: width_p] & {width_p{rev_open_reg}};
  end

  assign node_reset_o    = reset_i | node_held_reg;
  assign iso_o           = iso_reg;
  assign drain_timeout_o = drain_timeout_reg;

endmodule

// File: tb/tb_bsg_fsb_node_iso_ls.sv
// Bench for bsg_fsb_node_iso_ls: fixed vector table, corner-case sequences and
// random traffic, all checked against a phase-level reference model.
module tb_bsg_fsb_node_iso_ls;

  localparam int W  = 5;
  localparam int N  = 2;
  localparam int Q  = 2;
  localparam int T  = 8;
  localparam int WK = 4;
  localparam int DW = N * W;

  logic clk = 1'b0;
  logic reset, iso_req;
  logic [N-1:0]  fsb_v_o, node_ready_o, node_v_o, fsb_yumi_o;
  logic [DW-1:0] fsb_data_o, node_data_o;
  logic [N-1:0]  node_v_i, fsb_ready_i, fsb_v_i, node_yumi_i;
  logic [DW-1:0] node_data_i, fsb_data_i;
  logic node_reset, iso, dto;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: phase 0 active, 1 drain, 2 isolated, 3 wake
  int m_ph, m_drain, m_idle, m_wake;
  bit m_to;

  always #5 clk = ~clk;

  bsg_fsb_node_iso_ls #(
    .width_p(W), .num_ch_p(N), .drain_quiet_p(Q),
    .drain_timeout_p(T), .wake_cycles_p(WK)
  ) dut (
    .clk_i(clk), .reset_i(reset), .iso_req_i(iso_req),
    .fsb_v_o_i(fsb_v_o), .fsb_data_o_i(fsb_data_o), .node_ready_o_i(node_ready_o),
    .node_v_i_o(node_v_i), .node_data_i_o(node_data_i), .fsb_ready_i_o(fsb_ready_i),
    .node_v_o_i(node_v_o), .node_data_o_i(node_data_o), .fsb_yumi_o_i(fsb_yumi_o),
    .fsb_v_i_o(fsb_v_i), .fsb_data_i_o(fsb_data_i), .node_yumi_i_o(node_yumi_i),
    .node_reset_o(node_reset), .iso_o(iso), .drain_timeout_o(dto)
  );

  typedef struct {
    bit          req;
    logic [N-1:0] nv;
    logic        e_iso;
    logic        e_nrst;
    logic        e_to;
    logic [N-1:0] e_node_v;
    logic [DW-1:0] e_node_d;
    logic [N-1:0] e_fsb_v;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_ph = 0; m_drain = 0; m_idle = 0; m_wake = 0; m_to = 0;
    end else begin
      case (m_ph)
        0: if (iso_req) begin m_ph = 1; m_drain = 0; m_idle = 0; end
        1: begin
          m_drain++;
          m_idle = (node_v_o == '0) ? m_idle + 1 : 0;
          if (m_idle >= Q) m_ph = 2;
          else if (m_drain >= T) begin m_ph = 2; m_to = 1; end
        end
        2: if (!iso_req) begin m_ph = 3; m_wake = 0; end
        default: begin
          if (iso_req) m_ph = 2;
          else begin
            m_wake++;
            if (m_wake >= WK) begin m_ph = 0; m_to = 0; end
          end
        end
      endcase
    end
  endtask

  task automatic check_model();
    bit fwd, rev;
    fwd = (m_ph == 0);
    rev = (m_ph <= 1);
    chk("node_v_i_o",    node_v_i,    fsb_v_o & {N{fwd}});
    chk("node_data_i_o", node_data_i, fsb_data_o & {DW{fwd}});
    chk("fsb_ready_i_o", fsb_ready_i, node_ready_o & {N{fwd}});
    chk("fsb_v_i_o",     fsb_v_i,     node_v_o & {N{rev}});
    chk("fsb_data_i_o",  fsb_data_i,  node_data_o & {DW{rev}});
    chk("node_yumi_i_o", node_yumi_i, fsb_yumi_o & {N{rev}});
    chk("iso_o",         iso,         m_ph == 2);
    chk("node_reset_o",  node_reset,  reset || m_ph >= 2);
    chk("drain_timeout", dto,         m_to);
  endtask

  task automatic sample();
    @(negedge clk);
    check_model();
    $display("cyc %0d rst=%b req=%b nvo=%b ph=%0d iso=%b nrst=%b to=%b",
             cyc, reset, iso_req, node_v_o, m_ph, iso, node_reset, dto);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    iso_req = 1'b0;
    run(1);
    reset = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin #2000000; $display("FAIL watchdog cyc=%0d", cyc); $fatal(1); end

  initial begin
    reset = 1'b1; iso_req = 1'b0;
    fsb_v_o = '0; fsb_data_o = '0; node_ready_o = '0;
    node_v_o = '0; node_data_o = '0; fsb_yumi_o = '0;
    m_ph = 0; m_drain = 0; m_idle = 0; m_wake = 0; m_to = 0;
    @(posedge clk); model_edge(); #1;
    run(1);
    reset = 1'b0;

    // drain to quiet, isolate, wake back to active
    vecs[0]  = '{0, 2'b00, 0, 0, 0, 2'b11, 10'h2A5, 2'b00};
    vecs[1]  = '{1, 2'b00, 0, 0, 0, 2'b11, 10'h2A5, 2'b00};
    vecs[2]  = '{1, 2'b00, 0, 0, 0, 2'b00, 10'h000, 2'b00};
    vecs[3]  = '{0, 2'b00, 0, 0, 0, 2'b00, 10'h000, 2'b00};
    vecs[4]  = '{0, 2'b10, 1, 1, 0, 2'b00, 10'h000, 2'b00};
    vecs[5]  = '{0, 2'b10, 0, 1, 0, 2'b00, 10'h000, 2'b00};
    vecs[6]  = '{0, 2'b10, 0, 1, 0, 2'b00, 10'h000, 2'b00};
    vecs[7]  = '{0, 2'b10, 0, 1, 0, 2'b00, 10'h000, 2'b00};
    vecs[8]  = '{0, 2'b10, 0, 1, 0, 2'b00, 10'h000, 2'b00};
    vecs[9]  = '{0, 2'b10, 0, 0, 0, 2'b11, 10'h2A5, 2'b10};
    vecs[10] = '{0, 2'b01, 0, 0, 0, 2'b11, 10'h2A5, 2'b01};
    fsb_v_o = 2'b11; fsb_data_o = 10'h2A5; node_ready_o = 2'b11;
    node_data_o = 10'h155; fsb_yumi_o = 2'b00;
    foreach (vecs[i]) begin
      iso_req  = vecs[i].req;
      node_v_o = vecs[i].nv;
      sample();
      chk("tbl_iso",    iso,         vecs[i].e_iso);
      chk("tbl_nrst",   node_reset,  vecs[i].e_nrst);
      chk("tbl_to",     dto,         vecs[i].e_to);
      chk("tbl_node_v", node_v_i,    vecs[i].e_node_v);
      chk("tbl_node_d", node_data_i, vecs[i].e_node_d);
      chk("tbl_fsb_v",  fsb_v_i,     vecs[i].e_fsb_v);
      advance();
    end

    // drain timeout with a node that never goes quiet
    do_reset();
    iso_req = 1'b1; node_v_o = 2'b01;
    run(1);
    for (int k = 1; k <= T; k++) begin
      sample();
      chk("drain_fsb_v", fsb_v_i, 2'b01);
      chk("drain_iso", iso, 1'b0);
      advance();
    end
    sample();
    chk("timeout_iso", iso, 1'b1);
    chk("timeout_flag", dto, 1'b1);
    chk("timeout_fsb_v", fsb_v_i, 2'b00);
    iso_req = 1'b0;
    advance();
    for (int k = 1; k <= WK; k++) begin
      sample();
      chk("wake_nrst", node_reset, 1'b1);
      chk("wake_to_sticky", dto, 1'b1);
      advance();
    end
    sample();
    chk("wake_done_nrst", node_reset, 1'b0);
    chk("wake_done_to", dto, 1'b0);
    advance();

    // quiet reached on the same cycle as the timeout
    do_reset();
    iso_req = 1'b1; node_v_o = 2'b10;
    run(T - Q + 1);
    node_v_o = 2'b00;
    run(Q);
    sample();
    chk("tie_iso", iso, 1'b1);
    chk("tie_to", dto, 1'b0);
    advance();

    // re-isolate during wake, then a full wake period
    iso_req = 1'b0;
    run(2);
    iso_req = 1'b1;
    run(1);
    sample();
    chk("rewake_iso", iso, 1'b1);
    iso_req = 1'b0;
    advance();
    for (int k = 1; k <= WK; k++) begin
      sample();
      chk("rewake_nrst", node_reset, 1'b1);
      chk("rewake_iso0", iso, 1'b0);
      advance();
    end
    sample();
    chk("rewake_active", node_reset, 1'b0);
    advance();

    // reset in the middle of a drain
    do_reset();
    iso_req = 1'b1; node_v_o = 2'b11;
    run(4);
    reset = 1'b1;
    sample();
    chk("mid_rst_nrst", node_reset, 1'b1);
    advance();
    reset = 1'b0;
    sample();
    chk("post_rst_pass", node_v_i, fsb_v_o);
    advance();
    run(T);
    sample();
    chk("post_rst_timeout_iso", iso, 1'b1);
    iso_req = 1'b0;
    advance();
    run(WK + 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      fsb_v_o      = N'($urandom);
      fsb_data_o   = DW'($urandom);
      node_ready_o = N'($urandom);
      node_data_o  = DW'($urandom);
      fsb_yumi_o   = N'($urandom);
      node_v_o     = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom);
      if ($urandom_range(0, 11) == 0) iso_req = ~iso_req;
      reset = ($urandom_range(0, 149) == 0);
      run(1);
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
